// File: rtl/vid_text_pkg.sv
// Shared types and geometry for the text-mode scan-out path.
package vid_text_pkg;

   localparam int unsigned CHAR_W = 8;
   localparam int unsigned CHAR_H = 8;
   localparam int unsigned CG_AW  = 11;
   localparam int unsigned BIT_W  = $clog2(CHAR_W);

   typedef enum logic [1:0] {
      IDLE,
      VRD,
      CRD,
      CWT
   } fetch_state_e;

endpackage

// File: rtl/vid_pix_shifter.sv
// Glyph double buffer and MSB-first pixel serialiser with sticky underrun detection.
module vid_pix_shifter
   import vid_text_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              restart,
   input  logic              pix_ce,
   input  logic              hact,
   input  logic              fill,
   input  logic [CHAR_W-1:0] glyph,
   input  logic              col_left,
   input  logic              clr_underrun,
   output logic              buf_vld,
   output logic              pixel,
   output logic              underrun
);

   logic [CHAR_W-1:0] glyph_buf;
   logic [CHAR_W-1:0] sr;
   logic [BIT_W-1:0]  bit_cnt;
   logic              cell_start;
   logic              consume;
   logic              starve;

   assign cell_start = pix_ce & hact & (bit_cnt == '0);
   assign consume    = cell_start & buf_vld;
   // An empty buffer at a cell boundary is only an error while columns remain.
   assign starve     = cell_start & ~buf_vld & col_left & ~restart;

   // Glyph buffer: a fill only happens while empty, so it never meets a consume.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         glyph_buf <= '0;
         buf_vld   <= 1'b0;
      end else if (restart) begin
         buf_vld <= 1'b0;
      end else if (fill) begin
         glyph_buf <= glyph;
         buf_vld   <= 1'b1;
      end else if (consume) begin
         buf_vld <= 1'b0;
      end
   end

   // Serialiser: a starved cell shifts out zeros.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr      <= '0;
         bit_cnt <= '0;
         pixel   <= 1'b0;
      end else if (restart) begin
         sr      <= '0;
         bit_cnt <= '0;
         pixel   <= 1'b0;
      end else if (pix_ce) begin
         if (!hact) begin
            pixel <= 1'b0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == '0) begin
               sr    <= buf_vld ? (glyph_buf << 1) : '0;
               pixel <= buf_vld & glyph_buf[CHAR_W-1];
            end else begin
               sr    <= sr << 1;
               pixel <= sr[CHAR_W-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         underrun <= 1'b0;
      end else if (starve) begin
         underrun <= 1'b1;
      end else if (clr_underrun) begin
         underrun <= 1'b0;
      end
   end

endmodule

// File: rtl/vid_text_fetch.sv
// Text-mode scan-out sequencer: VRAM code fetch, chargen row fetch, pixel serialisation.
// Optional build macro VID_CURSOR_EN adds cursor_addr/cursor_on glyph inversion.
module vid_text_fetch
   import vid_text_pkg::*;
#(
   parameter int unsigned COLS = 32,
   parameter int unsigned VA_W = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pix_ce,
   input  logic             line_start,
   input  logic [7:0]       line,
   input  logic             hact,
   output logic [VA_W-1:0]  vram_addr,
   input  logic [7:0]       vram_din,
   output logic [CG_AW-1:0] cg_addr,
   input  logic [7:0]       cg_din,
   output logic             pixel,
   output logic             underrun,
   input  logic             clr_underrun
`ifdef VID_CURSOR_EN
   ,
   input  logic [VA_W-1:0]  cursor_addr,
   input  logic             cursor_on
`endif
);

   localparam int unsigned COL_W = $clog2(COLS + 1);

   fetch_state_e      state;
   fetch_state_e      state_nxt;
   logic              cwt_wait;
   logic [COL_W-1:0]  col;
   logic              col_left;
   logic              buf_vld;
   logic              load_vaddr;
   logic              load_cgaddr;
   logic              fill;
   logic [VA_W-1:0]   vaddr_c;
   logic [CHAR_W-1:0] glyph;

   assign col_left = (col < COL_W'(COLS));
   assign vaddr_c  = VA_W'(32'(line[7:3]) * COLS + 32'(col));

`ifdef VID_CURSOR_EN
   // vram_addr still holds this cell's address while its glyph returns.
   assign glyph = (cursor_on && (vram_addr == cursor_addr)) ? ~cg_din : cg_din;
`else
   assign glyph = cg_din;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // CWT spans two clks: one for the ROM to register cg_addr, one to capture cg_din.
   always_comb begin
      state_nxt   = state;
      load_vaddr  = 1'b0;
      load_cgaddr = 1'b0;
      fill        = 1'b0;
      case (state)
         IDLE: begin
            if (!buf_vld && col_left) begin
               state_nxt  = VRD;
               load_vaddr = 1'b1;
            end
         end
         VRD: state_nxt = CRD;
         CRD: begin
            load_cgaddr = 1'b1;
            state_nxt   = CWT;
         end
         CWT: begin
            if (cwt_wait) begin
               fill      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (line_start) begin
         state_nxt   = IDLE;
         load_vaddr  = 1'b0;
         load_cgaddr = 1'b0;
         fill        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cwt_wait  <= 1'b0;
         col       <= '0;
         vram_addr <= '0;
         cg_addr   <= '0;
      end else begin
         cwt_wait <= (state == CWT) && !cwt_wait && !line_start;
         if (line_start) begin
            col <= '0;
         end else if (fill) begin
            col <= col + 1'b1;
         end
         if (load_vaddr) begin
            vram_addr <= vaddr_c;
         end
         if (load_cgaddr) begin
            cg_addr <= CG_AW'({vram_din, line[2:0]});
         end
      end
   end

   vid_pix_shifter u_shifter (
      .clk          (clk),
      .reset_n      (reset_n),
      .restart      (line_start),
      .pix_ce       (pix_ce),
      .hact         (hact),
      .fill         (fill),
      .glyph        (glyph),
      .col_left     (col_left),
      .clr_underrun (clr_underrun),
      .buf_vld      (buf_vld),
      .pixel        (pixel),
      .underrun     (underrun)
   );

endmodule
